i2c_arb: RTL
============

Name: i2c_arb

Overview:
- Two-port arbiter and sequencer that shares one i2c_dri instance between two independent transaction masters.
- Typical masters: port 0 = e2prom_rw, port 1 = a sensor/config poller.
- Latches a requester's command and issues exactly one i2c_exec pulse per transaction.
- Waits for i2c_done, then returns ack/read data and a done pulse to the owner only.
- Sits between the masters and i2c_dri, clocked by dri_clk.

Parameters:
- ADDR_W, 16, width of the storage-address field passed to i2c_dri.
- TIMEOUT_CYC, 4096, watchdog limit in clk cycles for one transaction (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  I2C driver clock (connected to dri_clk). Single clock domain.
- rst_n  in  1  synchronous, active-high reset (1 = reset, sampled on rising clk).
- req  in  2  per-port request level. Held high until that port's done pulse.
- rh_wl_in  in  2  per-port read-high/write-low.
- bit_ctrl_in  in  2  per-port address width select (1 = 16-bit).
- addr_in  in  2*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W].
- data_w_in  in  16  per-port write byte, port p at [p*8 +: 8].
- gnt  out  2  one-hot owner indication. High from the capture cycle through the done cycle.
- done  out  2  one-cycle completion pulse to the owner.
- ack_out  out  1  i2c_ack captured at completion (1 = NACK seen). Valid while done is high.
- data_r_out  out  8  read byte captured at completion. Holds its value until the next completion.
- i2c_exec  out  1  one-cycle start pulse to i2c_dri.
- i2c_rh_wl, bit_ctrl, i2c_addr[ADDR_W], i2c_data_w[8]  out  registered command to i2c_dri. Stable from the exec cycle until i2c_done.
- i2c_done  in  1  driver completion pulse.
- i2c_ack  in  1  driver ack flag.
- i2c_data_r  in  8  driver read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, gnt = 2'b00, state = IDLE, last-served pointer lp = 1 (so port 0 wins first).
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, pick the winner by round-robin: the port != lp wins when both request; otherwise the single requester wins.
  - Same cycle: register the winner's command fields into the i2c_* outputs, set the gnt bit, set lp = winner, go to ISSUE.
- ISSUE:
  - i2c_exec = 1 for exactly this cycle, then go to WAIT.
  - Latency from req rising in IDLE to i2c_exec is 2 cycles.
- WAIT:
  - Hold the command registers.
  - On i2c_done = 1: capture i2c_ack -> ack_out and i2c_data_r -> data_r_out (data_r_out is updated on writes too), then go to RESP.
- RESP:
  - done[owner] = 1 for one cycle.
  - gnt clears at the end of this cycle; go to IDLE.
  - Next arbitration happens in IDLE, so there is at least one idle cycle between transactions.
- Boundary conditions:
  - An i2c_done arriving in IDLE, ISSUE or RESP is ignored (no state change).
  - A req deasserted mid-transaction does not abort it; the done pulse is still emitted.
  - The other port's req may rise or fall at any time with no effect until IDLE.
  - Both ports requesting continuously gives strict alternation 0,1,0,1.
  - Command inputs are sampled only in the IDLE capture cycle; later changes are ignored.
  - rst_n during any state returns to the reset values next cycle. No done pulse is emitted.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC-1 without i2c_done: go to RESP with ack_out = 1 and data_r_out = 8'hFF.
  - Extra output port timeout (1 bit), pulsed together with done.
  - A late i2c_done after the timeout is ignored (see boundary rules).
- Undefined: no counter and no timeout port; WAIT waits forever.

Decomposition:
- Package i2c_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - Port index constants P0 = 0, P1 = 1.
  - Constant TIMEOUT_DATA = 8'hFF.
- Sub-module i2c_rr_pick: a combinational 2-way round-robin picker (req, lp -> one-hot winner). It is natural because it is reused later if the port count grows.
- Everything else lives in i2c_arb.

Test Plan:
- Single write: req = 01, rh_wl = 0, addr 16'h0010, data 8'h5A -> gnt = 01 at cycle 1; i2c_exec at cycle 2 with i2c_addr = 16'h0010 and i2c_data_w = 8'h5A; i2c_done at cycle 40 -> done = 01 at cycle 41 with ack_out = 0.
- Read path: port 1 reads addr 16'h0003; driver returns 8'hC3 with i2c_ack = 0 -> data_r_out = 8'hC3 and done = 10. gnt = 01 is never asserted.
- Contention: both req held high for 4 transactions -> grant order 0,1,0,1. Exactly one exec per grant. No overlap of gnt bits.
- Stray and late events:
  - i2c_done pulsed in IDLE -> no done output.
  - addr_in changed during WAIT -> i2c_addr unchanged.
  - req dropped during WAIT -> done still pulses.
- Reset mid-WAIT: rst_n = 1 for one cycle -> next cycle gnt = 0, busy = 0, exec = 0. A following req = 01 is served normally.
- I2C_ARB_TIMEOUT_EN with TIMEOUT_CYC = 16 and no i2c_done -> done and timeout pulse 16 cycles after WAIT entry, with ack_out = 1 and data_r_out = 8'hFF.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-port i2c_dri arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;

  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational 2-way round-robin picker: on contention the port that was not served last wins.
module i2c_rr_pick
  import i2c_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_lp,
  output logic [1:0] o_gnt
);

  logic w_both;

  assign w_both = &i_req;

  always_comb begin
    o_gnt     = 2'b00;
    o_gnt[P0] = i_req[P0] & (~w_both | i_lp);
    o_gnt[P1] = i_req[P1] & (~w_both | ~i_lp);
  end

endmodule

// File: rtl/i2c_arb.sv
// Two-port arbiter/sequencer in front of a single i2c_dri instance.
// Optional watchdog on the WAIT state is enabled with I2C_ARB_TIMEOUT_EN.
module i2c_arb
  import i2c_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [1:0]          rh_wl_in,
  input  logic [1:0]          bit_ctrl_in,
  input  logic [2*ADDR_W-1:0] addr_in,
  input  logic [15:0]         data_w_in,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                ack_out,
  output logic [7:0]          data_r_out,
  output logic                i2c_exec,
  output logic                i2c_rh_wl,
  output logic                bit_ctrl,
  output logic [ADDR_W-1:0]   i2c_addr,
  output logic [7:0]          i2c_data_w,
  input  logic                i2c_done,
  input  logic                i2c_ack,
  input  logic [7:0]          i2c_data_r,
  output logic                busy
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);

  arb_state_e        r_state, w_state_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic              r_lp, w_lp_nxt;
  logic              r_rh_wl, w_rh_wl_nxt;
  logic              r_bit_ctrl, w_bit_ctrl_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_data_w, w_data_w_nxt;
  logic              r_exec, w_exec_nxt;
  logic              r_ack, w_ack_nxt;
  logic [7:0]        r_data_r, w_data_r_nxt;
  logic [1:0]        w_win;
  logic              w_idx;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_to, w_to_nxt;
`endif

  i2c_rr_pick u_pick (
    .i_req (req),
    .i_lp  (r_lp),
    .o_gnt (w_win)
  );

  assign w_idx = w_win[P1];

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_lp_nxt       = r_lp;
    w_rh_wl_nxt    = r_rh_wl;
    w_bit_ctrl_nxt = r_bit_ctrl;
    w_addr_nxt     = r_addr;
    w_data_w_nxt   = r_data_w;
    w_exec_nxt     = 1'b0;
    w_ack_nxt      = r_ack;
    w_data_r_nxt   = r_data_r;
`ifdef I2C_ARB_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_to_nxt       = r_to;
`endif
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt    = ISSUE;
          w_gnt_nxt      = w_win;
          w_lp_nxt       = w_idx;
          w_rh_wl_nxt    = rh_wl_in[w_idx];
          w_bit_ctrl_nxt = bit_ctrl_in[w_idx];
          w_addr_nxt     = w_idx ? addr_in[ADDR_W +: ADDR_W] : addr_in[0 +: ADDR_W];
          w_data_w_nxt   = w_idx ? data_w_in[8 +: 8] : data_w_in[0 +: 8];
        end
      end
      ISSUE: begin
        // exec is registered so it lands in the first WAIT cycle
        w_exec_nxt  = 1'b1;
        w_state_nxt = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
      end
      WAIT: begin
        if (i2c_done) begin
          w_ack_nxt    = i2c_ack;
          w_data_r_nxt = i2c_data_r;
          w_state_nxt  = RESP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_ack_nxt    = 1'b1;
          w_data_r_nxt = TIMEOUT_DATA;
          w_to_nxt     = 1'b1;
          w_state_nxt  = RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
        w_to_nxt    = 1'b0;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= 2'b00;
      r_lp       <= 1'b1;
      r_rh_wl    <= 1'b0;
      r_bit_ctrl <= 1'b0;
      r_addr     <= '0;
      r_data_w   <= '0;
      r_exec     <= 1'b0;
      r_ack      <= 1'b0;
      r_data_r   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_lp       <= w_lp_nxt;
      r_rh_wl    <= w_rh_wl_nxt;
      r_bit_ctrl <= w_bit_ctrl_nxt;
      r_addr     <= w_addr_nxt;
      r_data_w   <= w_data_w_nxt;
      r_exec     <= w_exec_nxt;
      r_ack      <= w_ack_nxt;
      r_data_r   <= w_data_r_nxt;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_to  <= w_to_nxt;
    end
  end

  assign timeout = r_to & (r_state == RESP);
`endif

  assign gnt        = r_gnt;
  assign done       = (r_state == RESP) ? r_gnt : 2'b00;
  assign ack_out    = r_ack;
  assign data_r_out = r_data_r;
  assign i2c_exec   = r_exec;
  assign i2c_rh_wl  = r_rh_wl;
  assign bit_ctrl   = r_bit_ctrl;
  assign i2c_addr   = r_addr;
  assign i2c_data_w = r_data_w;
  assign busy       = (r_state != IDLE);

endmodule
